// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: valid/ready word in, start + LSB-first data + optional parity + stop out.
// Every bit is held on tx_out for CLKS_PER_BIT clocks; tx_out, busy and frame_done are registered.
//
// state  | meaning
// IDLE   | line high, tx_ready high, waiting for tx_valid
// START  | start bit (0) on the line
// DATA   | payload bits, LSB first, one per bit period
// PARITY | parity bit (only reached when PARITY_EN=1)
// STOP   | stop bit (1); frame_done pulses on the first IDLE cycle after it
module serial_frame_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  current_state, next_state;
    logic [BAUD_W-1:0]       baud_cnt, baud_next;
    logic [BIT_W-1:0]        bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic                    parity_bit, parity_next;
    logic                    tx_out_next, busy_next, done_next;
    logic                    baud_wrap;

    assign tx_ready  = (current_state == IDLE);
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_comb begin
        next_state  = current_state;
        baud_next   = baud_wrap ? '0 : baud_cnt + BAUD_ONE;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        tx_out_next = tx_out;
        busy_next   = busy;
        done_next   = 1'b0;

        case (current_state)
            IDLE: begin
                baud_next   = '0;
                bit_next    = '0;
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
                if (tx_valid) begin
                    next_state  = START;
                    shift_next  = tx_data;
                    parity_next = (^tx_data) ^ ODD_BIT;
                    tx_out_next = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    next_state  = DATA;
                    bit_next    = '0;
                    tx_out_next = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt == BIT_LAST) begin
                        if (HAS_PAR) begin
                            next_state  = PARITY;
                            tx_out_next = parity_bit;
                        end else begin
                            next_state  = STOP;
                            tx_out_next = 1'b1;
                        end
                    end else begin
                        // The next bit to show is whatever lands in bit 0 after the shift.
                        shift_next  = shift_reg >> 1;
                        bit_next    = bit_cnt + BIT_ONE;
                        tx_out_next = shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    next_state  = STOP;
                    tx_out_next = 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    next_state  = IDLE;
                    tx_out_next = 1'b1;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                end
            end
            default: begin
                next_state  = IDLE;
                baud_next   = '0;
                bit_next    = '0;
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            current_state <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            tx_out        <= 1'b1;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            current_state <= next_state;
            baud_cnt      <= baud_next;
            bit_cnt       <= bit_next;
            shift_reg     <= shift_next;
            parity_bit    <= parity_next;
            tx_out        <= tx_out_next;
            busy          <= busy_next;
            frame_done    <= done_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (even parity, odd parity, no parity) share one
// producer; a frame-timeline model is compared every cycle and a bench-side receiver decodes the line.
module tb_serial_frame_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] rdy, line, bsy, done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .tx_out(line[0]), .busy(bsy[0]), .frame_done(done[0]));
    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .tx_out(line[1]), .busy(bsy[1]), .frame_done(done[1]));
    serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) u_nop (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[2]), .tx_out(line[2]), .busy(bsy[2]), .frame_done(done[2]));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit-per-period vector: [0]=start, [8:1]=data LSB first, then parity, then stop.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input bit pen, input bit podd);
        logic [15:0] f;
        f      = '0;
        f[8:1] = d;
        if (pen) f[9] = (^d) ^ podd;
        f[9 + int'(pen)] = 1'b1;
        return f;
    endfunction

    // Model: remaining cycles of the current frame per instance, plus its bit vector.
    bit          pen_k [3] = '{1, 1, 0};
    bit          podd_k[3] = '{0, 1, 0};
    logic [15:0] fbits [3];
    int          rem   [3];
    int          nper  [3];
    logic        mdone [3];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 3; k++) begin
                rem[k]   <= 0;
                mdone[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] > 0) begin
                    rem[k]   <= rem[k] - 1;
                    mdone[k] <= (rem[k] == 1);
                end else begin
                    mdone[k] <= 1'b0;
                    if (tx_valid) begin
                        fbits[k] <= build_frame(tx_data, pen_k[k], podd_k[k]);
                        nper[k]  <= 10 + int'(pen_k[k]);
                        rem[k]   <= (10 + int'(pen_k[k])) * C;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic el;
            el = (rem[k] > 0) ? fbits[k][(nper[k] * C - rem[k]) / C] : 1'b1;
            check($sformatf("tx_out[%0d]", k), 32'(line[k]), 32'(el));
            check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(rem[k] > 0));
            check($sformatf("tx_ready[%0d]", k), 32'(rdy[k]), 32'(rem[k] == 0));
            check($sformatf("frame_done[%0d]", k), 32'(done[k]), 32'(mdone[k]));
        end
    end

    // Receiver on the even-parity line: samples mid-bit after a falling edge.
    logic [7:0] rx_q[$];
    bit         rx_ok[$];
    bit         rx_en = 1'b1;

    initial begin
        logic [7:0] b;
        logic       st, par, sp;
        forever begin
            @(negedge clk);
            if (rx_en && n_rst === 1'b1 && line[0] === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                st = line[0];
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = line[0];
                end
                repeat (C) @(negedge clk);
                par = line[0];
                repeat (C) @(negedge clk);
                sp = line[0];
                rx_q.push_back(b);
                rx_ok.push_back(st == 1'b0 && sp == 1'b1 && par == ^b);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (rdy !== 3'b111 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=%b required=111", rdy);
        end
    endtask

    task automatic send_even(input logic [7:0] v);
        int n = 0;
        tx_data  = v;
        tx_valid = 1'b1;
        while (rdy[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_even_timeout actual=%b required=1", rdy[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] lit_a5;
        int          pulses;
        lit_a5   = 11'b10101001010;
        n_rst    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;

        check("model_a5_even", 32'(build_frame(8'hA5, 1'b1, 1'b0)), 32'h054A);
        check("model_01_odd", 32'(build_frame(8'h01, 1'b1, 1'b1)), 32'h0402);
        check("model_01_even", 32'(build_frame(8'h01, 1'b1, 1'b0)), 32'h0602);
        check("model_01_nopar", 32'(build_frame(8'h01, 1'b0, 1'b0)), 32'h0202);

        // Idle after reset
        repeat (100) @(negedge clk);
        check("idle_line", 32'(line), 32'h7);
        check("idle_ready", 32'(rdy), 32'h7);
        check("idle_busy", 32'(bsy), 32'h0);
        check("idle_done", 32'(done), 32'h0);

        // 0xA5, single-cycle valid
        wait_idle();
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 46; c++) begin
            if (c % 4 == 2 && c / 4 < 11) check($sformatf("a5_period%0d", c / 4), 32'(line[0]), 32'(lit_a5[c / 4]));
            if (c == 39) check("nop_ready_c39", 32'(rdy[2]), 32'h0);
            if (c == 40) check("nop_ready_c40", 32'(rdy[2]), 32'h1);
            if (c == 43) check("a5_ready_c43", 32'(rdy[0]), 32'h0);
            if (c == 44) check("a5_ready_c44", 32'(rdy[0]), 32'h1);
            pulses += int'(done[0]);
            @(negedge clk);
        end
        check("a5_done_pulses", 32'(pulses), 32'h1);

        // 0x01: parity bit per flavour
        wait_idle();
        tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 0; c < 46; c++) begin
            if (c == 6)  check("x01_bit0", 32'(line), 32'h7);
            if (c == 34) check("x01_bit7", 32'(line), 32'h0);
            if (c == 38) begin
                check("x01_par_even", 32'(line[0]), 32'h1);
                check("x01_par_odd", 32'(line[1]), 32'h0);
                check("x01_nopar_stop", 32'(line[2]), 32'h1);
            end
            @(negedge clk);
        end

        // Back-to-back with data churn
        wait_idle();
        rx_q.delete(); rx_ok.delete();
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 47; c++) begin
            if (c >= 1 && c < 30) tx_data = 8'($urandom);
            if (c == 30) tx_data = 8'hC3;
            if (c == 44) begin
                check("b2b_gap_done", 32'(done[0]), 32'h1);
                check("b2b_gap_line", 32'(line[0]), 32'h1);
            end
            if (c == 45) check("b2b_start2", 32'(line[0]), 32'h0);
            if (c == 46) tx_valid = 1'b0;
            @(negedge clk);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("b2b_rx_count", 32'(rx_q.size()), 32'h2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", 32'(rx_q[0]), 32'h3C);
            check("b2b_rx1", 32'(rx_q[1]), 32'hC3);
        end

        // Asynchronous reset during data bit 3 of 0xFF
        rx_en = 1'b0;
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_busy", 32'(bsy[0]), 32'h1);
        #1 n_rst = 1'b0;
        #1;
        check("async_line", 32'(line), 32'h7);
        check("async_busy", 32'(bsy), 32'h0);
        check("async_ready", 32'(rdy), 32'h7);
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        rx_q.delete(); rx_ok.delete();
        rx_en = 1'b1;
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("post_rst_count", 32'(rx_q.size()), 32'h1);
        if (rx_q.size() == 1) check("post_rst_byte", 32'(rx_q[0]), 32'h55);

        // Random valid/data traffic
        for (int i = 0; i < 3000; i++) begin
            tx_valid = ($urandom_range(0, 7) < 3);
            tx_data  = 8'($urandom);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);

        // Loopback of all byte values
        rx_q.delete(); rx_ok.delete();
        for (int v = 0; v < 256; v++) send_even(8'(v));
        tx_valid = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("loop_count", 32'(rx_q.size()), 32'd256);
        if (rx_q.size() == 256) begin
            for (int v = 0; v < 256; v++) begin
                check($sformatf("loop_byte%0d", v), 32'(rx_q[v]), 32'(v));
                check($sformatf("loop_frame%0d", v), 32'(rx_ok[v]), 32'h1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
FSM-based serial frame transmitter. It is the transmit-side counterpart to the team's single-bit-input FSM receivers/detectors. It accepts a parallel word through a valid/ready handshake and serialises it onto one line. The frame is: start bit, data LSB-first, optional parity, stop bit. Each bit is held for a fixed number of clock cycles. It sits between a parallel producer and a serial link whose far end is a receiver FSM.

Parameters:
DATA_WIDTH, 8, payload bits per frame (1..16)
CLKS_PER_BIT, 16, clock cycles each bit is held on tx_out (>= 2)
PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  word to send, sampled only on handshake
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line, idle high, registered
busy  output  1  frame in progress, registered
frame_done  output  1  single-cycle pulse on the cycle after the stop bit completes, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting n_rst forces the following immediately, mid-frame included, with no partial frame resumed:
  - state=IDLE, tx_out=1, busy=0, frame_done=0
  - baud/bit counters=0, shift register=0
  - tx_ready=1 (decoded from state)
- States: IDLE, START, DATA, PARITY, STOP. A current_state/next_state register pair is used. Next-state and output logic are combinational with safe defaults (no latches). tx_out, busy and frame_done are registered.
- Handshake: transfer occurs on the rising edge where tx_valid=1 and tx_ready=1.
  - On that edge: capture tx_data into the shift register; compute the parity bit = ^tx_data XOR PARITY_ODD; go to START; tx_out<=0; busy<=1.
  - tx_data/tx_valid changes outside a transfer are ignored. tx_valid may drop without a transfer and has no effect.
- Bit timing: the baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. Each bit is on tx_out for exactly CLKS_PER_BIT cycles. State advances when the counter wraps to 0.
- START -> DATA: tx_out = shift[0].
- DATA: shift right on each wrap. The bit counter counts 0..DATA_WIDTH-1. After the last data bit:
  - PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_out = parity bit for one bit period -> STOP.
- STOP: tx_out=1 for one bit period. At its end:
  - next state IDLE, busy<=0, frame_done<=1 for exactly one cycle.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles from the handshake edge to the return to IDLE.
- tx_ready is 0 from the handshake edge until the return to IDLE.
- Back-to-back: tx_valid held high gives the next handshake on the first IDLE cycle. There is a minimum gap of one cycle of tx_out=1 beyond the stop bit between frames.
- Widths: the baud counter is $clog2(CLKS_PER_BIT) bits and the bit counter is $clog2(DATA_WIDTH)+1 bits. No counter may overflow at the maximum parameter values.
- Unused state encodings return to IDLE with tx_out=1.

Test Plan:
- Reset idle: n_rst low then high, no tx_valid, CLKS_PER_BIT=4 -> tx_out=1, tx_ready=1, busy=0, frame_done=0 held for 100 cycles.
- Even-parity frame: DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0, send 0xA5.
  - tx_out per 4-cycle period = 0,1,0,1,0,0,1,0,1,0(parity),1(stop); 44 cycles total.
  - frame_done pulses once; tx_ready returns high at cycle 44.
- Odd parity / no parity: send 0x01.
  - PARITY_ODD=1 -> parity bit 0.
  - PARITY_ODD=0 -> parity bit 1.
  - PARITY_EN=0 -> no parity period, frame length 40 cycles.
- Back-to-back with data churn: tx_valid held high with 0x3C then 0xC3, tx_data toggled randomly mid-frame.
  - Both frames decode exactly 0x3C, 0xC3.
  - Exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2.
- Reset mid-frame: assert n_rst asynchronously (between clock edges) during the DATA bit 3 period of 0xFF.
  - tx_out=1 and busy=0 immediately, without waiting for a clock edge.
  - After release, a new 0x55 frame transmits correctly from its start bit.
- Receiver loopback: tx_out connected to the team's serial receiver FSM; 256 frames, all values 0x00..0xFF -> every received byte and parity check matches.
